// File: rtl/sigmoid_grad.sv
// rtl/sigmoid_grad.sv - sigmoid backward pass: grad_out = g * y * (1 - y), Q16.16 out, one shared multiplier
module sigmoid_grad #(
    parameter int GW = 32,
    parameter int YW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [YW-1:0] in_y,
    input  logic [GW-1:0] in_grad,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [GW-1:0] grad_out,
    output logic          out_clamp
);

    localparam int YF = YW - 1;
    localparam int PW = GW + YW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [YW-1:0]   r_y;
    logic [GW-1:0]   r_g;
    logic [YW-1:0]   r_d;
    logic            r_clamp;
    logic [GW-1:0]   r_grad_out;
    logic            r_out_clamp;
    logic            r_out_valid;

    logic                 w_accept;
    logic [YW-1:0]        w_yc;
    logic [YW:0]          w_one_minus_y;
    logic signed [GW-1:0] w_op_a;
    logic signed [YW:0]   w_op_b;
    logic signed [PW-1:0] w_prod;
    logic [YW-1:0]        w_d;
    logic [GW-1:0]        w_grad;

    assign in_ready  = rst_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign grad_out  = r_grad_out;
    assign out_clamp = r_out_clamp;

    // Negative activations are outside the sigmoid range; treat them as 0.
    assign w_yc          = r_y[YW-1] ? '0 : r_y;
    assign w_one_minus_y = ((YW + 1)'(1) << YF) - {1'b0, w_yc};

    // MUL1 forms y*(1-y); every other state presents g*d to the multiplier.
    always_comb begin
        w_op_a = signed'(r_g);
        w_op_b = signed'({1'b0, r_d});
        if (r_state == S_MUL1) begin
            w_op_a = signed'(GW'(w_yc));
            w_op_b = signed'(w_one_minus_y);
        end
    end

    assign w_prod = PW'(w_op_a) * PW'(w_op_b);
    assign w_d    = YW'(w_prod >> YF);
    assign w_grad = GW'(w_prod >>> YF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_y         <= '0;
            r_g         <= '0;
            r_d         <= '0;
            r_clamp     <= 1'b0;
            r_grad_out  <= '0;
            r_out_clamp <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_y     <= in_y;
                        r_g     <= in_grad;
                        r_state <= S_MUL1;
                    end
                end
                S_MUL1: begin
                    r_d     <= w_d;
                    r_clamp <= r_y[YW-1];
                    r_state <= S_MUL2;
                end
                S_MUL2: begin
                    r_grad_out  <= w_grad;
                    r_out_clamp <= r_clamp;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_y     <= in_y;
                            r_g     <= in_grad;
                            r_state <= S_MUL1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_grad.sv
// tb/tb_sigmoid_grad.sv - scoreboard bench for sigmoid_grad with a reference model
module tb_sigmoid_grad;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_y;
    logic [31:0] in_grad;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] grad_out;
    logic        out_clamp;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_g[$];
    logic        exp_c[$];
    int          lat_q[$];

    sigmoid_grad dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_y     (in_y),
        .in_grad  (in_grad),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .grad_out (grad_out),
        .out_clamp(out_clamp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // y*(1-y) in Q1.15 then g*d scaled back, floor division on the signed product.
    function automatic logic [31:0] model_grad(input logic [15:0] y, input logic [31:0] g);
        longint yc, d, num, q;
        yc  = y[15] ? 64'sd0 : longint'(y);
        d   = (yc * (32768 - yc)) / 32768;
        num = longint'($signed(g)) * d;
        q   = num / 32768;
        if (num < 0 && (num % 32768) != 0) q = q - 1;
        return q[31:0];
    endfunction

    task automatic send(input logic [15:0] y, input logic [31:0] g, input logic [31:0] eg,
                        input logic ec, input bit push, output int acc);
        in_valid = 1'b1;
        in_y     = y;
        in_grad  = g;
        if (push) begin
            exp_g.push_back(eg);
            exp_c.push_back(ec);
        end
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        if (acc < 0) flag("accept_timeout");
        else if (push) lat_q.push_back(acc);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_g.size() != 0) && (n < 100)) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_g.size() != 0) flag("drain_timeout");
    endtask

    // Monitor: compares every handshaken result and checks valid/data hold under backpressure.
    initial begin : monitor
        logic        prev_valid;
        logic        prev_ready;
        logic [31:0] prev_grad;
        logic [31:0] eg;
        logic        ec;
        int          a;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_grad  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_grad", 64'(grad_out), 64'(prev_grad));
                end
                if (out_valid && !prev_valid) begin
                    if (lat_q.size() == 0) flag("unexpected_valid");
                    else begin
                        a = lat_q.pop_front();
                        chk("latency", 64'(cyc), 64'(a + 2));
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_g.size() == 0) flag("unexpected_result");
                    else begin
                        eg = exp_g.pop_front();
                        ec = exp_c.pop_front();
                        chk("grad_out", 64'(grad_out), 64'(eg));
                        chk("out_clamp", 64'(out_clamp), 64'(ec));
                    end
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_grad  = grad_out;
            end
        end
    end

    initial begin : stimulus
        int          acc;
        int          prev_acc;
        int          n;
        logic [15:0] ry;
        logic [31:0] rg;
        logic [31:0] bp_exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_y      = '0;
        in_grad   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_grad_out", 64'(grad_out), 64'd0);
        chk("rst_out_clamp", 64'(out_clamp), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed points with hand-derived expectations.
        send(16'h4000, 32'h0001_0000, 32'h0000_4000, 1'b0, 1'b1, acc);
        send(16'h6000, 32'hFFFE_0000, 32'hFFFF_A000, 1'b0, 1'b1, acc);
        send(16'h0000, $urandom, 32'h0000_0000, 1'b0, 1'b1, acc);
        send(16'h7FFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, acc);
        send(16'h8000, $urandom, 32'h0000_0000, 1'b1, 1'b1, acc);
        send(16'h2000, 32'h0010_0000, 32'h0003_0000, 1'b0, 1'b1, acc);
        wait_drain();

        // Reset while the operation is in MUL2: nothing may be emitted.
        send(16'h4000, 32'h0004_0000, 32'h0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_grad_out", 64'(grad_out), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_output", 64'(out_valid), 64'd0);

        // Backpressure: hold the result, then consume and accept on the same edge.
        out_ready = 1'b0;
        ry = 16'h3000;
        rg = 32'hFFF3_5A21;
        bp_exp = model_grad(ry, rg);
        send(ry, rg, bp_exp, 1'b0, 1'b1, acc);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) flag("bp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_grad_out", 64'(grad_out), 64'(bp_exp));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        ry = 16'h5A5A;
        rg = 32'h0123_4567;
        send(ry, rg, model_grad(ry, rg), 1'b0, 1'b1, acc);
        wait_drain();

        // Streaming: back-to-back accepts must land every 3 cycles.
        @(posedge clk);
        #1;
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            ry = 16'($urandom);
            rg = $urandom;
            send(ry, rg, model_grad(ry, rg), ry[15], 1'b1, acc);
            if (i > 0) chk("stream_spacing", 64'(acc - prev_acc), 64'd3);
            prev_acc = acc;
        end
        wait_drain();

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 30; i++) begin
            ry = 16'($urandom);
            rg = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            fork
                begin
                    for (int k = 0; k < 12; k++) begin
                        @(posedge clk);
                        #2;
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    out_ready = 1'b1;
                end
                send(ry, rg, model_grad(ry, rg), ry[15], 1'b1, acc);
            join_any
            wait fork;
        end
        out_ready = 1'b1;
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        chk("final_lat_queue_empty", 64'(lat_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
